// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state encoding and parameter-byte helper for the LCD rectangle scheduler.
package lcd_pkg;
  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam int H_RES_DEF = 240;
  localparam int V_RES_DEF = 320;
  localparam logic DC_CMD = 1'b0;
  localparam logic DC_DATA = 1'b1;
  typedef enum logic [3:0] {IDLE, GRANT, CASET, CASET_P, RASET, RASET_P, RAMWR, PIXEL, DONE} state_t;
  function automatic logic [8:0] param_byte(input logic [1:0] i, input logic [8:0] a, input logic [8:0] b);
    return {DC_DATA, i == 2'd0 ? {7'd0, a[8]} : i == 2'd1 ? a[7:0] : i == 2'd2 ? {7'd0, b[8]} : b[7:0]};
  endfunction
endpackage

// File: rtl/lcd_rect_scheduler_if.sv
// lcd_rect_scheduler_if: client request bus plus the byte-writer handshake.
interface lcd_rect_scheduler_if #(parameter int N_REQ = 2);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*9-1:0] req_x0;
  logic [N_REQ*9-1:0] req_x1;
  logic [N_REQ*9-1:0] req_y0;
  logic [N_REQ*9-1:0] req_y1;
  logic [N_REQ*16-1:0] req_color;
  logic [8:0] lcd_data;
  logic lcd_en;
  logic lcd_wr_done;
  modport slave (input req_valid, req_x0, req_x1, req_y0, req_y1, req_color, lcd_wr_done, output req_ready, lcd_data, lcd_en);
  modport master (output req_valid, req_x0, req_x1, req_y0, req_y1, req_color, lcd_wr_done, input req_ready, lcd_data, lcd_en);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester at or after the priority pointer.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic [N_REQ-1:0] req,
  input  logic adv,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] c;
  logic found;
  always_comb begin
    idx = '0;
    found = 1'b0;
    c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      c = IW'((int'(ptr) + i) % N_REQ);
      if (!found && req[c]) begin
        found = 1'b1;
        idx = c;
      end
    end
    gnt = '0;
    if (found) gnt[idx] = 1'b1;
  end
  always_ff @(posedge clk_50MHz or posedge rst)
    if (rst) ptr <= '0;
    else if (adv) ptr <= idx == IW'(N_REQ - 1) ? '0 : idx + 1'b1;
endmodule

// File: rtl/lcd_rect_scheduler.sv
// lcd_rect_scheduler: arbitrates rectangle fills and streams CASET/RASET/RAMWR plus
// solid RGB565 pixels through the shared byte writer.
module lcd_rect_scheduler import lcd_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic clk_50MHz,
  input  logic rst,
  input  logic init_done,
  lcd_rect_scheduler_if.slave bus,
  output logic busy,
  output logic [IW-1:0] grant_id,
  output logic done,
  output logic err
);
  localparam logic [8:0] XMAX = 9'(H_RES - 1);
  localparam logic [8:0] YMAX = 9'(V_RES - 1);
  state_t state;
  logic [8:0] x0, x1, y0, y1, sx0, sx1, sy0, sy1, w, h;
  logic [15:0] color, scol;
  logic [16:0] npix;
  logic [1:0] pidx;
  logic phase, bad, sbad, adv, step;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0] gidx;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk_50MHz(clk_50MHz),
    .rst(rst),
    .req(bus.req_valid),
    .adv(adv),
    .gnt(gnt),
    .idx(gidx)
  );
  assign sx0 = bus.req_x0[9*int'(gidx) +: 9];
  assign sx1 = bus.req_x1[9*int'(gidx) +: 9];
  assign sy0 = bus.req_y0[9*int'(gidx) +: 9];
  assign sy1 = bus.req_y1[9*int'(gidx) +: 9];
  assign scol = bus.req_color[16*int'(gidx) +: 16];
  assign sbad = sx0 > sx1 || sx1 > XMAX || sy0 > sy1 || sy1 > YMAX;
  assign adv = state == IDLE && init_done && |bus.req_valid;
  assign step = bus.lcd_en && bus.lcd_wr_done;
  assign w = x1 - x0 + 9'd1;
  assign h = y1 - y0 + 9'd1;
  // Request fields are captured on the accept edge so the client may drop them right after req_ready.
  always_ff @(posedge clk_50MHz or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.req_ready <= '0;
      bus.lcd_data <= '0;
      bus.lcd_en <= 1'b0;
      busy <= 1'b0;
      grant_id <= '0;
      done <= 1'b0;
      err <= 1'b0;
      {x0, x1, y0, y1} <= '0;
      color <= '0;
      npix <= '0;
      pidx <= '0;
      phase <= 1'b0;
      bad <= 1'b0;
    end else begin
      bus.req_ready <= '0;
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (adv) begin
          state <= GRANT;
          bus.req_ready <= gnt;
          grant_id <= gidx;
          {x0, x1, y0, y1} <= {sx0, sx1, sy0, sy1};
          color <= scol;
          bad <= sbad;
          err <= sbad;
          busy <= !sbad;
        end
        GRANT: if (bad) state <= IDLE;
        else begin
          state <= CASET;
          npix <= 17'(w) * 17'(h);
          bus.lcd_en <= 1'b1;
          bus.lcd_data <= {DC_CMD, CMD_CASET};
        end
        CASET: if (step) begin
          state <= CASET_P;
          pidx <= 2'd0;
          bus.lcd_data <= param_byte(2'd0, x0, x1);
        end
        CASET_P: if (step) begin
          pidx <= pidx + 2'd1;
          state <= pidx == 2'd3 ? RASET : CASET_P;
          bus.lcd_data <= pidx == 2'd3 ? {DC_CMD, CMD_RASET} : param_byte(pidx + 2'd1, x0, x1);
        end
        RASET: if (step) begin
          state <= RASET_P;
          pidx <= 2'd0;
          bus.lcd_data <= param_byte(2'd0, y0, y1);
        end
        RASET_P: if (step) begin
          pidx <= pidx + 2'd1;
          state <= pidx == 2'd3 ? RAMWR : RASET_P;
          bus.lcd_data <= pidx == 2'd3 ? {DC_CMD, CMD_RAMWR} : param_byte(pidx + 2'd1, y0, y1);
        end
        RAMWR: if (step) begin
          state <= PIXEL;
          phase <= 1'b0;
          bus.lcd_data <= {DC_DATA, color[15:8]};
        end
        PIXEL: if (step) begin
          phase <= ~phase;
          if (!phase) bus.lcd_data <= {DC_DATA, color[7:0]};
          else begin
            npix <= npix - 17'd1;
            if (npix == 17'd1) begin
              state <= DONE;
              bus.lcd_en <= 1'b0;
              done <= 1'b1;
              busy <= 1'b0;
            end else bus.lcd_data <= {DC_DATA, color[15:8]};
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lcd_rect_scheduler.sv
// tb_lcd_rect_scheduler: scoreboard bench; stimulus pushes expected bytes/grants, a monitor pops and compares.
module tb_lcd_rect_scheduler;
  import lcd_pkg::*;
  localparam int N = 2;
  logic clk_50MHz = 1'b0;
  logic rst = 1'b1;
  logic init_done = 1'b0;
  logic busy, done, err;
  logic [0:0] grant_id;
  lcd_rect_scheduler_if #(.N_REQ(N)) bus ();
  lcd_rect_scheduler #(.N_REQ(N)) dut (
    .clk_50MHz(clk_50MHz),
    .rst(rst),
    .init_done(init_done),
    .bus(bus),
    .busy(busy),
    .grant_id(grant_id),
    .done(done),
    .err(err)
  );
  always #10 clk_50MHz = ~clk_50MHz;

  int vecs = 0, miss = 0, dly = 1, nbytes = 0;
  logic [8:0] exp_b[$];
  logic [N-1:0] exp_rdy[$];
  int exp_done[$];
  int exp_err[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    vecs++;
    miss++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // byte-writer model: wr_done pulses after dly enabled cycles
  initial begin
    int c = 0;
    bus.lcd_wr_done = 1'b0;
    forever begin
      @(posedge clk_50MHz);
      #1;
      if (rst) begin
        c = 0;
        bus.lcd_wr_done = 1'b0;
      end else if (bus.lcd_wr_done) begin
        bus.lcd_wr_done = 1'b0;
        c = 0;
      end else if (bus.lcd_en) begin
        c++;
        if (c >= dly) bus.lcd_wr_done = 1'b1;
      end
    end
  end

  always @(negedge clk_50MHz)
    if (!rst) begin
      if (bus.lcd_en && bus.lcd_wr_done) begin
        nbytes++;
        if (exp_b.size() == 0) unexpected("lcd_byte", 32'(bus.lcd_data));
        else chk("lcd_byte", 32'(bus.lcd_data), 32'(exp_b.pop_front()));
      end
      if (|bus.req_ready) begin
        if (exp_rdy.size() == 0) unexpected("req_ready", 32'(bus.req_ready));
        else chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy.pop_front()));
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("done_id", 32'(grant_id));
        else chk("done_id", 32'(grant_id), 32'(exp_done.pop_front()));
      end
      if (err) begin
        if (exp_err.size() == 0) unexpected("err_id", 32'(grant_id));
        else chk("err_id", 32'(grant_id), 32'(exp_err.pop_front()));
      end
    end

  task automatic set_cl(input int i, input logic [8:0] x0, y0, x1, y1, input logic [15:0] c);
    bus.req_x0[9*i +: 9] = x0;
    bus.req_y0[9*i +: 9] = y0;
    bus.req_x1[9*i +: 9] = x1;
    bus.req_y1[9*i +: 9] = y1;
    bus.req_color[16*i +: 16] = c;
  endtask

  task automatic issue(input int i, input logic [8:0] x0, y0, x1, y1, input logic [15:0] c);
    logic [N-1:0] r;
    int npx;
    set_cl(i, x0, y0, x1, y1, c);
    r = '0;
    r[i] = 1'b1;
    exp_rdy.push_back(r);
    if (x0 > x1 || x1 >= 240 || y0 > y1 || y1 >= 320) exp_err.push_back(i);
    else begin
      exp_b.push_back(9'h02A);
      exp_b.push_back({8'h80, x0[8]});
      exp_b.push_back({1'b1, x0[7:0]});
      exp_b.push_back({8'h80, x1[8]});
      exp_b.push_back({1'b1, x1[7:0]});
      exp_b.push_back(9'h02B);
      exp_b.push_back({8'h80, y0[8]});
      exp_b.push_back({1'b1, y0[7:0]});
      exp_b.push_back({8'h80, y1[8]});
      exp_b.push_back({1'b1, y1[7:0]});
      exp_b.push_back(9'h02C);
      npx = (int'(x1) - int'(x0) + 1) * (int'(y1) - int'(y0) + 1);
      for (int p = 0; p < npx; p++) begin
        exp_b.push_back({1'b1, c[15:8]});
        exp_b.push_back({1'b1, c[7:0]});
      end
      exp_done.push_back(i);
    end
  endtask

  task automatic wait_end(input string name, input int n, input int budget);
    int k = 0;
    for (int t = 0; t < budget && k < n; t++) begin
      @(negedge clk_50MHz);
      if (done || err) k++;
    end
    bus.req_valid = '0;
    chk({name, "_ends"}, 32'(k), 32'(n));
    @(negedge clk_50MHz);
    chk({name, "_leftover"}, 32'(exp_b.size() + exp_rdy.size() + exp_done.size() + exp_err.size()), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({name, "_lcd_data"}, 32'(bus.lcd_data), 32'd0);
    chk({name, "_lcd_en"}, 32'(bus.lcd_en), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [8:0] lit [15];
    int k, lat, n0;
    lit = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02B, 9'h100, 9'h100,
            9'h100, 9'h100, 9'h02C, 9'h1F8, 9'h100, 9'h1F8, 9'h100};
    bus.req_valid = '0;
    bus.req_x0 = '0;
    bus.req_x1 = '0;
    bus.req_y0 = '0;
    bus.req_y1 = '0;
    bus.req_color = '0;
    repeat (3) @(negedge clk_50MHz);
    chk_outputs_zero("reset");
    rst = 1'b0;
    // init_done gating, then the two-pixel red fill
    set_cl(0, 9'd0, 9'd0, 9'd1, 9'd0, 16'hF800);
    exp_rdy.push_back(2'b01);
    foreach (lit[i]) exp_b.push_back(lit[i]);
    exp_done.push_back(0);
    dly = 8;
    bus.req_valid = 2'b01;
    k = 0;
    repeat (100) begin
      @(negedge clk_50MHz);
      if (|bus.req_ready || bus.lcd_en) k++;
    end
    chk("gated_activity", 32'(k), 32'd0);
    @(posedge clk_50MHz);
    #1 init_done = 1'b1;
    lat = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk_50MHz);
      lat++;
      if (|bus.req_ready) break;
    end
    chk("grant_latency", 32'(lat), 32'd2);
    wait_end("red_fill", 1, 2000);
    dly = 1;
    // x1 equal to H_RES is rejected without any LCD traffic
    n0 = nbytes;
    issue(1, 9'd0, 9'd0, 9'd240, 9'd0, 16'h1111);
    bus.req_valid = 2'b10;
    wait_end("reject_x", 1, 50);
    repeat (4) @(negedge clk_50MHz);
    chk("reject_bytes", 32'(nbytes - n0), 32'd0);
    chk("reject_busy", 32'(busy), 32'd0);
    chk("reject_en", 32'(bus.lcd_en), 32'd0);
    // both clients hold requests: grants must alternate 0,1,0,1
    issue(0, 9'd2, 9'd3, 9'd3, 9'd3, 16'h1234);
    issue(1, 9'd5, 9'd5, 9'd5, 9'd6, 16'hABCD);
    issue(0, 9'd2, 9'd3, 9'd3, 9'd3, 16'h1234);
    issue(1, 9'd5, 9'd5, 9'd5, 9'd6, 16'hABCD);
    bus.req_valid = 2'b11;
    wait_end("alternate", 4, 1000);
    // far corner with the largest legal coordinates
    issue(0, 9'd230, 9'd310, 9'd239, 9'd319, 16'h07E0);
    bus.req_valid = 2'b01;
    wait_end("corner", 1, 3000);
    issue(0, 9'd100, 9'd300, 9'd100, 9'd300, 16'hFFFF);
    bus.req_valid = 2'b01;
    wait_end("one_pixel", 1, 200);
    issue(0, 9'd0, 9'd5, 9'd0, 9'd4, 16'h0000);
    bus.req_valid = 2'b01;
    wait_end("reject_y_order", 1, 50);
    issue(1, 9'd0, 9'd0, 9'd0, 9'd320, 16'h0000);
    bus.req_valid = 2'b10;
    wait_end("reject_y_range", 1, 50);
    // reset in the middle of the pixel stream; pointer was left at client 1
    issue(0, 9'd0, 9'd0, 9'd9, 9'd9, 16'h5555);
    bus.req_valid = 2'b01;
    n0 = nbytes;
    for (int t = 0; t < 300 && nbytes - n0 < 14; t++) @(negedge clk_50MHz);
    chk("mid_pixel_reached", 32'(nbytes - n0 >= 14), 32'd1);
    #3 rst = 1'b1;
    bus.req_valid = '0;
    exp_b.delete();
    exp_rdy.delete();
    exp_done.delete();
    exp_err.delete();
    @(negedge clk_50MHz);
    chk_outputs_zero("mid_reset");
    @(negedge clk_50MHz);
    rst = 1'b0;
    issue(0, 9'd7, 9'd8, 9'd7, 9'd8, 16'hC3A5);
    issue(1, 9'd1, 9'd2, 9'd2, 9'd2, 16'h0F0F);
    bus.req_valid = 2'b11;
    wait_end("post_reset", 2, 500);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
